vram_arb: RTL and testbench

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/vram_arb_if.sv | 34 +++
 rtl/vram_arb.sv | 120 ++++++++++++
 tb/tb_vram_arb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_if.sv
// Bus bundle between the VRAM arbiter and its clients: scanout reads,
// CPU write requests and the VRAM port-B pins.
interface vram_arb_if #(
  parameter int AW = 10
) ();
  logic          vsync;
  logic          lcd_req;
  logic [AW-1:0] lcd_addr;
  logic [7:0]    lcd_data;
  logic          lcd_valid;
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [7:0]    cpu_wr_data;
  logic          cpu_wr_ack;
  logic          cpu_full;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_ad;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic [7:0]    ovf_cnt;

  modport slave (
    input  vsync, lcd_req, lcd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data, ram_dout,
    output lcd_data, lcd_valid, cpu_wr_ack, cpu_full,
           ram_ce, ram_we, ram_ad, ram_din, ovf_cnt
  );

  modport master (
    output vsync, lcd_req, lcd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data, ram_dout,
    input  lcd_data, lcd_valid, cpu_wr_ack, cpu_full,
           ram_ce, ram_we, ram_ad, ram_din, ovf_cnt
  );
endinterface

// File: rtl/vram_arb.sv
// VRAM port-B arbiter: scanout reads win over queued CPU writes.
// Define VRAM_ARB_VBLANK_ONLY_EN to restrict CPU drain to vsync=1.
module vram_arb #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input logic       PixelClk,
  input logic       nRST,
  vram_arb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vram_arb: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, LCD_RD, CPU_WR} grant_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_req_t;

  grant_e        state_q, state_d;
  wr_req_t       fifo_mem [DEPTH];
  wr_req_t       head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, drain_ok;

  logic [AW-1:0] ram_ad_q;
  logic [7:0]    ram_din_q;
  logic          ack_q, lcd_valid_q;
  logic [7:0]    lcd_hold_q;
  logic [7:0]    ovf_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push  = bus.cpu_wr_req & ~full;
  assign head  = fifo_mem[rptr];

`ifdef VRAM_ARB_VBLANK_ONLY_EN
  assign drain_ok = bus.vsync;
`else
  logic unused_vsync;
  assign unused_vsync = bus.vsync;
  assign drain_ok     = 1'b1;
`endif

  always_comb begin
    state_d = IDLE;
    pop     = 1'b0;
    if (bus.lcd_req) begin
      state_d = LCD_RD;
    end else if (!empty && drain_ok) begin
      state_d = CPU_WR;
      pop     = 1'b1;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (push) fifo_mem[wptr] <= wr_req_t'{addr: bus.cpu_wr_addr, data: bus.cpu_wr_data};
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
      ack_q       <= 1'b0;
      lcd_valid_q <= 1'b0;
      lcd_hold_q  <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= push;
      lcd_valid_q <= (state_q == LCD_RD);
      if (lcd_valid_q) lcd_hold_q <= bus.ram_dout;
      case (state_d)
        LCD_RD: ram_ad_q <= bus.lcd_addr;
        CPU_WR: begin
          ram_ad_q  <= head.addr;
          ram_din_q <= head.data;
        end
        default: ;
      endcase
      if (bus.cpu_wr_req && full && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end
  end

  // Read data arrives the cycle after LCD_RD; pass it straight through
  // on the strobe and hold the last value afterwards.
  assign bus.lcd_data   = lcd_valid_q ? bus.ram_dout : lcd_hold_q;
  assign bus.lcd_valid  = lcd_valid_q;
  assign bus.ram_ce     = (state_q != IDLE);
  assign bus.ram_we     = (state_q == CPU_WR);
  assign bus.ram_ad     = ram_ad_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.cpu_wr_ack = ack_q;
  assign bus.cpu_full   = full;
  assign bus.ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb with a behavioural port-B VRAM model.
module tb_vram_arb;
  logic PixelClk = 1'b0;
  logic nRST     = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  logic [7:0] vram [1024];

  vram_arb_if #(.AW(10)) bus ();
  vram_arb #(.AW(10), .DEPTH(4)) dut (.PixelClk(PixelClk), .nRST(nRST), .bus(bus));

  always #5 PixelClk = ~PixelClk;

  // VRAM model: registered read, one-cycle latency.
  always @(posedge PixelClk) begin
    if (bus.ram_ce && bus.ram_we)  vram[bus.ram_ad] <= bus.ram_din;
    if (bus.ram_ce && !bus.ram_we) bus.ram_dout <= vram[bus.ram_ad];
  end

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ram_ce"},    bus.ram_ce,     0);
    chk({tag, " ram_we"},    bus.ram_we,     0);
    chk({tag, " ram_ad"},    bus.ram_ad,     0);
    chk({tag, " ram_din"},   bus.ram_din,    0);
    chk({tag, " lcd_valid"}, bus.lcd_valid,  0);
    chk({tag, " lcd_data"},  bus.lcd_data,   0);
    chk({tag, " ack"},       bus.cpu_wr_ack, 0);
    chk({tag, " ovf"},       bus.ovf_cnt,    0);
    chk({tag, " full"},      bus.cpu_full,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
    bus.ram_dout    = 8'h00;
    bus.lcd_req     = 1'b0;
    bus.lcd_addr    = '0;
    bus.cpu_wr_req  = 1'b0;
    bus.cpu_wr_addr = '0;
    bus.cpu_wr_data = '0;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
    bus.vsync = 1'b1;
`else
    bus.vsync = 1'b0;
`endif
    tick(); tick();
    chk_reset_outs("reset");
    nRST = 1'b1;
    tick();

    // Single write while idle: ack next cycle, VRAM write the cycle after.
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'd5; bus.cpu_wr_data = 8'h41;
    tick();
    chk("s1 ack", bus.cpu_wr_ack, 1);
    chk("s1 we early", bus.ram_we, 0);
    bus.cpu_wr_req = 1'b0;
    tick();
    chk("s1 we", bus.ram_we, 1);
    chk("s1 ce", bus.ram_ce, 1);
    chk("s1 ad", bus.ram_ad, 5);
    chk("s1 din", bus.ram_din, 8'h41);
    chk("s1 ack drop", bus.cpu_wr_ack, 0);
    tick();
    chk("s1 idle we", bus.ram_we, 0);
    chk("s1 idle ce", bus.ram_ce, 0);
    chk("s1 vram", vram[5], 8'h41);

    // Scanout read of a preloaded location.
    vram[7] = 8'h5A;
    bus.lcd_req = 1'b1; bus.lcd_addr = 10'd7;
    tick();
    chk("s2 ce", bus.ram_ce, 1);
    chk("s2 we", bus.ram_we, 0);
    chk("s2 ad", bus.ram_ad, 7);
    chk("s2 valid early", bus.lcd_valid, 0);
    bus.lcd_req = 1'b0;
    tick();
    chk("s2 valid", bus.lcd_valid, 1);
    chk("s2 data", bus.lcd_data, 8'h5A);
    tick();
    chk("s2 valid drop", bus.lcd_valid, 0);
    chk("s2 data hold", bus.lcd_data, 8'h5A);

    // LCD request collides with a queued write: read first.
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'd9; bus.cpu_wr_data = 8'h33;
    tick();
    chk("s3 ack", bus.cpu_wr_ack, 1);
    bus.cpu_wr_req = 1'b0;
    bus.lcd_req = 1'b1; bus.lcd_addr = 10'd7;
    tick();
    chk("s3 rd ce", bus.ram_ce, 1);
    chk("s3 rd we", bus.ram_we, 0);
    chk("s3 rd ad", bus.ram_ad, 7);
    bus.lcd_req = 1'b0;
    tick();
    chk("s3 valid", bus.lcd_valid, 1);
    chk("s3 data", bus.lcd_data, 8'h5A);
    chk("s3 we", bus.ram_we, 1);
    chk("s3 ad", bus.ram_ad, 9);
    chk("s3 din", bus.ram_din, 8'h33);
    tick();

    // LCD hogs the port: FIFO fills, overflow counter runs, then drains in order.
    bus.lcd_req = 1'b1; bus.lcd_addr = 10'd0;
    bus.cpu_wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_wr_addr = 10'h10 + 10'(i); bus.cpu_wr_data = 8'hA0 + 8'(i);
      tick();
      chk("s4 push ack", bus.cpu_wr_ack, 1);
    end
    bus.cpu_wr_addr = 10'h14; bus.cpu_wr_data = 8'hA4;
    chk("s4 full", bus.cpu_full, 1);
    chk("s4 ovf0", bus.ovf_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("s4 held ack", bus.cpu_wr_ack, 0);
      chk("s4 held we", bus.ram_we, 0);
      chk("s4 ovf", bus.ovf_cnt, i);
    end
    bus.lcd_req = 1'b0;
    tick();
    chk("s4 drain we", bus.ram_we, 1);
    chk("s4 drain ad0", bus.ram_ad, 10'h10);
    chk("s4 drain din0", bus.ram_din, 8'hA0);
    chk("s4 ovf final", bus.ovf_cnt, 4);
    chk("s4 not full", bus.cpu_full, 0);
    tick();
    chk("s4 late ack", bus.cpu_wr_ack, 1);
    bus.cpu_wr_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("s4 order we", bus.ram_we, 1);
      chk("s4 order ad", bus.ram_ad, 10'h10 + 10'(i));
      chk("s4 order din", bus.ram_din, 8'hA0 + 8'(i));
      tick();
    end
    chk("s4 empty we", bus.ram_we, 0);
    chk("s4 ovf kept", bus.ovf_cnt, 4);

    // Overflow counter saturates, then async reset clears everything.
    bus.lcd_req = 1'b1;
    bus.cpu_wr_req = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("sat full", bus.cpu_full, 1);
    chk("sat ovf", bus.ovf_cnt, 8'hFF);
    nRST = 1'b0;
    #1;
    chk_reset_outs("async rst");
    bus.lcd_req = 1'b0; bus.cpu_wr_req = 1'b0;
    tick();
    nRST = 1'b1;
    tick();

    // Reset with three queued writes: they vanish without acks.
    bus.lcd_req = 1'b1;
    bus.cpu_wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr_addr = 10'h20 + 10'(i); bus.cpu_wr_data = 8'hC0 + 8'(i);
      tick();
      chk("r3 ack", bus.cpu_wr_ack, 1);
    end
    bus.cpu_wr_req = 1'b0;
    chk("r3 not full", bus.cpu_full, 0);
    nRST = 1'b0;
    #1;
    chk("r3 ovf", bus.ovf_cnt, 0);
    chk("r3 ack clr", bus.cpu_wr_ack, 0);
    chk("r3 ce clr", bus.ram_ce, 0);
    bus.lcd_req = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r3 no we", bus.ram_we, 0);
      chk("r3 no ack", bus.cpu_wr_ack, 0);
    end
    chk("r3 vram untouched", vram[10'h20], 8'h00);

`ifdef VRAM_ARB_VBLANK_ONLY_EN
    // Drain only in vertical blanking.
    bus.vsync = 1'b0;
    bus.cpu_wr_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cpu_wr_addr = 10'h30 + 10'(i); bus.cpu_wr_data = 8'h70 + 8'(i);
      tick();
      chk("vb ack", bus.cpu_wr_ack, 1);
    end
    bus.cpu_wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("vb blocked we", bus.ram_we, 0);
      tick();
    end
    bus.vsync = 1'b1;
    tick();
    chk("vb we0", bus.ram_we, 1);
    chk("vb ad0", bus.ram_ad, 10'h30);
    tick();
    chk("vb we1", bus.ram_we, 1);
    chk("vb ad1", bus.ram_ad, 10'h31);
    chk("vb din1", bus.ram_din, 8'h71);
    tick();
    chk("vb done", bus.ram_we, 0);
`else
    // Drain runs regardless of vsync.
    bus.vsync = 1'b0;
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 10'h30; bus.cpu_wr_data = 8'h77;
    tick();
    chk("nv ack", bus.cpu_wr_ack, 1);
    bus.cpu_wr_req = 1'b0;
    tick();
    chk("nv we", bus.ram_we, 1);
    chk("nv ad", bus.ram_ad, 10'h30);
    chk("nv din", bus.ram_din, 8'h77);
    tick();
    chk("nv done", bus.ram_we, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
